tinyalu_requester: RTL

TINYALU_REQUESTER -- requirements
Module: tinyalu_requester

---
 rtl/tinyalu_requester_if.sv | 27 ++
 rtl/tinyalu_requester.sv | 99 +++++++++
 2 files changed

// File: rtl/tinyalu_requester_if.sv
// tinyalu_requester_if: command, response and TinyALU signal bundle of the requester
interface tinyalu_requester_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic [1:0]  rsp_err;
    logic        alu_start;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_done;
    logic [15:0] alu_result;
    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err, alu_start, alu_a, alu_b, alu_op
    );
    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err, alu_start, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/tinyalu_requester.sv
// tinyalu_requester: queues commands, drives the TinyALU handshake, returns in-order responses
package tinyalu_pkg;
    typedef enum logic [2:0] {
        no_op      = 3'b000,
        add_op     = 3'b001,
        and_op     = 3'b010,
        xor_op     = 3'b011,
        mul_op     = 3'b100,
        illegal_op = 3'b111
    } opcode_t;
    function automatic opcode_t logic_to_opcode(input logic [2:0] op);
        return op == 3'b000 ? no_op  : op == 3'b001 ? add_op : op == 3'b010 ? and_op :
               op == 3'b011 ? xor_op : op == 3'b100 ? mul_op : illegal_op;
    endfunction
endpackage

module tinyalu_requester
    import tinyalu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input logic clk,
    input logic reset_n,
    tinyalu_requester_if.master bus
);
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {idle, issue_nop, busy, resp} state_t;
    state_t        state, state_n;
    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tcnt;
    logic [7:0]    a_q, b_q;
    logic [2:0]    op_q;
    logic [15:0]   result_q;
    logic [1:0]    err_q;
    logic          ready_en, push, pop, timed_out;
    opcode_t       head_op;
    assign bus.cmd_ready  = ready_en && reset_n && count != CW'(FIFO_DEPTH);
    assign push           = bus.cmd_valid && bus.cmd_ready;
    assign pop            = state == idle && count != '0;
    assign head_op        = logic_to_opcode(mem[rd_ptr][2:0]);
    assign timed_out      = tcnt == TW'(TIMEOUT - 1);
    assign bus.alu_start  = state == busy || state == issue_nop;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_valid  = state == resp;
    assign bus.rsp_result = result_q;
    assign bus.rsp_op     = op_q;
    assign bus.rsp_err    = err_q;
    always_comb begin
        state_n = state;
        case (state)
            idle:      if (pop) state_n = head_op == illegal_op ? resp : head_op == no_op ? issue_nop : busy;
            issue_nop: state_n = resp;
            busy:      if (bus.alu_done || timed_out) state_n = resp;
            default:   if (bus.rsp_ready) state_n = idle;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= idle;
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tcnt     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= '0;
        end else begin
            state    <= state_n;
            ready_en <= 1'b1;
            count    <= count + CW'(push) - CW'(pop);
            if (push) begin
                mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                {a_q, b_q, op_q} <= mem[rd_ptr];
                rd_ptr           <= rd_ptr + 1'b1;
                tcnt             <= '0;
                result_q         <= '0;
                err_q            <= head_op == illegal_op ? 2'b01 : 2'b00;
            end
            if (state == busy) begin
                tcnt <= tcnt + 1'b1;
                if (bus.alu_done) result_q <= bus.alu_result;
                else if (timed_out) err_q <= 2'b10;
            end
        end
    end
endmodule
